// File: rtl/pin_walker.sv
// pin_walker: board bring-up pin locator.
// Drives exactly one of NUM_PINS header pins high (or none) so a probe or LED
// can find it. Three active-low buttons, each debounced, step the selected pin
// up/down and cycle the display mode (STEADY, BLINK, AUTO, OFF).

// ---------------------------------------------------------------------------
// pin_walker_debounce: 2-flop synchroniser plus stability counter for one
// active-low button. 'pressed' is the accepted (debounced) level; 'press_pulse'
// is high for exactly one cycle when the accepted level flips to pressed.
// ---------------------------------------------------------------------------
module pin_walker_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] cnt_q;

  // Synchronised level, inverted so 1 means "button held down".
  assign level = ~sync_q[1];

  // Synchronise the raw pin and accept a new level once it has been stable
  // for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    // NOTE: every register is written with <= so all flops sample the values
    // from before this edge, whatever order the statements appear in.
    if (!resetn) begin
      sync_q      <= 2'b11;  // released: the raw button idles high
      pressed     <= 1'b0;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_n};
      press_pulse <= 1'b0;
      if (level == pressed) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        pressed     <= level;
        cnt_q       <= '0;
        press_pulse <= level;  // release flips the state but emits no pulse
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// pin_walker: top level.
// ---------------------------------------------------------------------------
module pin_walker #(
  parameter int NUM_PINS        = 48,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_CYCLES    = 6250000,
  parameter int AUTO_CYCLES     = 25000000,
  localparam int IDX_W          = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_mode,
  output logic [NUM_PINS-1:0] pins,
  output logic [IDX_W-1:0]    index,
  output logic [1:0]          mode,
  output logic                up_led,
  output logic                down_led
);

  // Display modes, in the order a mode press cycles through them.
  localparam logic [1:0] MODE_STEADY = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int AUTO_W  = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_PINS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [AUTO_W-1:0]  AUTO_LAST  = AUTO_W'(AUTO_CYCLES - 1);
  localparam logic [NUM_PINS-1:0] PIN_ZERO  = {{(NUM_PINS - 1){1'b0}}, 1'b1};

  // ---- button front ends -------------------------------------------------
  logic up_pulse;
  logic down_pulse;
  logic mode_pulse;
  logic mode_held;

  pin_walker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk         (clk),
    .resetn      (resetn),
    .btn_n       (btn_up),
    .pressed     (up_led),
    .press_pulse (up_pulse)
  );

  pin_walker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk         (clk),
    .resetn      (resetn),
    .btn_n       (btn_down),
    .pressed     (down_led),
    .press_pulse (down_pulse)
  );

  // The mode button's held level has no consumer; only its press pulse acts.
  pin_walker_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk         (clk),
    .resetn      (resetn),
    .btn_n       (btn_mode),
    .pressed     (mode_held),
    .press_pulse (mode_pulse)
  );

  // ---- mode / timer state ------------------------------------------------
  logic               phase_q;      // BLINK: 1 while the selected pin is lit
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [AUTO_W-1:0]  auto_cnt_q;

  // ---- next-state signals ------------------------------------------------
  logic                step_up;
  logic                step_down;
  logic                manual_step;
  logic                auto_wrap;
  logic                blink_wrap;
  logic                pin_on;
  logic [IDX_W-1:0]    idx_inc;
  logic [IDX_W-1:0]    idx_dec;
  logic [IDX_W-1:0]    index_nxt;
  logic [NUM_PINS-1:0] pins_nxt;

  // Index arithmetic with wrap at both ends; index never leaves 0..NUM_PINS-1.
  always_comb begin
    // NOTE: each signal gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx_inc = index + IDX_W'(1);
    idx_dec = index - IDX_W'(1);
    if (index == IDX_LAST) idx_inc = '0;
    if (index == '0)       idx_dec = IDX_LAST;
  end

  // Resolve the index update: manual steps cancel each other and take
  // priority over an AUTO timer wrap landing in the same cycle.
  always_comb begin
    step_up     = up_pulse & ~down_pulse;
    step_down   = down_pulse & ~up_pulse;
    manual_step = step_up | step_down;
    auto_wrap   = (mode == MODE_AUTO)  && (auto_cnt_q == AUTO_LAST);
    blink_wrap  = (mode == MODE_BLINK) && (blink_cnt_q == BLINK_LAST);
    index_nxt   = index;
    if (step_up)        index_nxt = idx_inc;
    else if (step_down) index_nxt = idx_dec;
    else if (auto_wrap) index_nxt = idx_inc;
  end

  // Pin decode from the current registered index, mode and phase; it is
  // registered again below, so pins trail index by one cycle.
  always_comb begin
    pin_on = 1'b0;
    case (mode)
      MODE_STEADY: pin_on = 1'b1;
      MODE_BLINK:  pin_on = phase_q;
      MODE_AUTO:   pin_on = 1'b1;
      MODE_OFF:    pin_on = 1'b0;
      default:     pin_on = 1'b0;
    endcase
    pins_nxt = pin_on ? (PIN_ZERO << index) : '0;
  end

  // Selection, mode, timers and registered pin drive.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      index       <= '0;
      mode        <= MODE_STEADY;
      pins        <= '0;
      phase_q     <= 1'b0;
      blink_cnt_q <= '0;
      auto_cnt_q  <= '0;
    end else begin
      index <= index_nxt;
      pins  <= pins_nxt;

      if (mode_pulse) begin
        // Every mode change restarts both timers and the blink phase, so
        // BLINK always opens with the pin dark for a full half-period.
        mode        <= mode + 2'd1;
        phase_q     <= 1'b0;
        blink_cnt_q <= '0;
        auto_cnt_q  <= '0;
      end else begin
        if (mode == MODE_BLINK) begin
          if (blink_wrap) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
          end
        end else begin
          blink_cnt_q <= '0;
          phase_q     <= 1'b0;
        end

        if (mode == MODE_AUTO) begin
          // A manual step restarts the dwell so the new pin gets a full one.
          if (manual_step || auto_wrap) auto_cnt_q <= '0;
          else                          auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
        end else begin
          auto_cnt_q <= '0;
        end
      end
    end
  end

endmodule
